gcm_input_loader: RTL and testbench



---
 rtl/gcm_input_loader.sv | 117 +++++++++++
 tb/tb_gcm_input_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_input_loader.sv
// Frame loader for the AES-256-GCM core: collects 30 big-endian words into the core operands,
// then holds them while driving a level start until the core has finished and released done.
module gcm_input_loader #(
    parameter int WORDS = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic [255:0] key,
    output logic [95:0]  nonce,
    output logic [127:0] plaintext1,
    output logic [127:0] plaintext2,
    output logic [127:0] plaintext3,
    output logic [223:0] aad,
    output logic         core_start,
    input  logic         core_done,
    output logic         frame_err,
    output logic [15:0]  frame_cnt
);

    // Handshake: a word moves on a rising edge where s_valid && s_ready; s_valid may rise
    // at any time, and s_ready depends only on state so upstream never sees a comb path back.

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int          FRAME_BITS = WORDS * 32;
    localparam logic [4:0]  LAST_IDX   = 5'(WORDS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [4:0]              idx;
    logic [FRAME_BITS-1:0]   frame_q;

    logic                    xfer;
    logic                    at_last;
    logic                    good_end;
    logic                    bad_end;

    assign s_ready    = (state == ST_LOAD);
    assign core_start = (state == ST_START);

    assign xfer     = s_valid && s_ready;
    assign at_last  = (idx == LAST_IDX);
    assign good_end = xfer && at_last && s_last;
    assign bad_end  = xfer && (s_last != at_last);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (good_end)   state_nxt = ST_START;
            ST_START: if (core_done)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!core_done) state_nxt = ST_LOAD;
            default:                  state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Any terminating word (good or malformed) restarts the word count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_end;
            if (xfer) begin
                if (s_last || at_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 5'd1;
                end
            end
        end
    end

    // Word 0 lands in the most significant slot, so the frame is one big-endian vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (xfer) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx == 5'(i)) begin
                    frame_q[(WORDS-1-i)*32 +: 32] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == ST_START && core_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign key        = frame_q[959:704];
    assign nonce      = frame_q[703:608];
    assign plaintext1 = frame_q[607:480];
    assign plaintext2 = frame_q[479:352];
    assign plaintext3 = frame_q[351:224];
    assign aad        = frame_q[223:0];

endmodule

// File: tb/tb_gcm_input_loader.sv
// Bench for gcm_input_loader: table of frames (good, stalled, early/missing last) with a
// word-queue reference model, a behavioural core, and hand sequences for reset and stray done.
module tb_gcm_input_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [127:0] plaintext1;
  logic [127:0] plaintext2;
  logic [127:0] plaintext3;
  logic [223:0] aad;
  logic         core_start;
  logic         core_done;
  logic         frame_err;
  logic [15:0]  frame_cnt;

  gcm_input_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .key        (key),
    .nonce      (nonce),
    .plaintext1 (plaintext1),
    .plaintext2 (plaintext2),
    .plaintext3 (plaintext3),
    .aad        (aad),
    .core_start (core_start),
    .core_done  (core_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural core ----------------
  int core_lat    = 50;
  int core_hold   = 1;
  bit core_manual = 1'b0;
  int lat_cnt     = 0;
  int hold_cnt    = 0;

  initial begin
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_done = 1'b0;
        lat_cnt   = 0;
        hold_cnt  = 0;
      end else if (!core_manual) begin
        if (core_done) begin
          if (hold_cnt > 1) hold_cnt--;
          else core_done = 1'b0;
        end else if (core_start) begin
          lat_cnt++;
          if (lat_cnt >= core_lat) begin
            core_done = 1'b1;
            hold_cnt  = core_hold;
            lat_cnt   = 0;
          end
        end
      end
    end
  end

  // ---------------- frame_err monitor ----------------
  int err_pulses = 0;
  int err_long   = 0;
  bit err_prev   = 1'b0;

  always @(negedge clk) begin
    if (frame_err) begin
      err_pulses++;
      if (err_prev) err_long++;
    end
    err_prev = frame_err;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]  exp_q[$];
  logic [959:0] exp_frame = '0;
  logic [15:0]  model_cnt = '0;

  // Each accepted word is queued; a frame is good only when its 30th word carries last.
  task automatic model_accept(input logic [31:0] w, input bit last);
    int pos;
    exp_q.push_back(w);
    pos = exp_q.size() - 1;
    if (last && pos == 29) begin
      exp_frame = '0;
      for (int k = 0; k < 30; k++) exp_frame = {exp_frame[927:0], exp_q.pop_front()};
    end else if (last || pos == 29) begin
      exp_q.delete();
    end
  endtask

  task automatic check_operands(input string tag);
    chk({tag, "_key"},   key,        exp_frame[959:704]);
    chk({tag, "_nonce"}, nonce,      exp_frame[703:608]);
    chk({tag, "_pt1"},   plaintext1, exp_frame[607:480]);
    chk({tag, "_pt2"},   plaintext2, exp_frame[479:352]);
    chk({tag, "_pt3"},   plaintext3, exp_frame[351:224]);
    chk({tag, "_aad"},   aad,        exp_frame[223:0]);
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic [31:0] w [30];
    int          last_pos;   // word index carrying s_last; -1 means never
    int          stall_pct;
    int          lat;
    int          hold;
    bit          exp_err;
    bit          exp_start;
  } vec_t;

  // Leaves the final word on the bus; the caller's next negedge sees its effect.
  task automatic send_frame(input vec_t v);
    int n;
    int i;
    int guard;
    n = (v.last_pos < 0) ? 30 : v.last_pos + 1;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (v.stall_pct > 0 && $urandom_range(99) < v.stall_pct) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(1));
      end else begin
        s_valid = 1'b1;
        s_data  = v.w[i];
        s_last  = (i == v.last_pos);
        if (s_ready) begin
          model_accept(v.w[i], i == v.last_pos);
          i++;
        end
      end
    end
    if (i < n) chk("send_budget", 256'(i), 256'(n));
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int p0;
    int hi;
    int lo;
    p0 = err_pulses;
    core_lat  = v.lat;
    core_hold = v.hold;
    send_frame(v);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (v.exp_start) begin
      chk($sformatf("v%0d_start_rise", id), 256'(core_start), 256'(1));
      chk($sformatf("v%0d_ready_low", id),  256'(s_ready),    256'(0));
      check_operands($sformatf("v%0d_load", id));
      hi = 0;
      while (core_start && hi < 500) begin
        hi++;
        @(negedge clk);
        s_valid = 1'($urandom_range(1));
        s_data  = $urandom;
      end
      chk($sformatf("v%0d_start_len", id), 256'(hi), 256'(v.lat));
      lo = 0;
      while (!s_ready && lo < 500) begin
        lo++;
        @(negedge clk);
        if (!s_ready) begin
          s_valid = 1'b1;
          s_data  = $urandom;
          s_last  = 1'($urandom_range(1));
        end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk($sformatf("v%0d_drain_len", id), 256'(lo), 256'(v.hold));
      model_cnt++;
      chk($sformatf("v%0d_frame_cnt", id), 256'(frame_cnt), 256'(model_cnt));
      check_operands($sformatf("v%0d_held", id));
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("v%0d_no_start", id), 256'(core_start), 256'(0));
        chk($sformatf("v%0d_ready", id),    256'(s_ready),    256'(1));
      end
      chk($sformatf("v%0d_cnt_hold", id), 256'(frame_cnt), 256'(model_cnt));
    end
    chk($sformatf("v%0d_err_pulses", id), 256'(err_pulses - p0), 256'(v.exp_err));
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // table of frames
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < 30; k++) vecs[v].w[k] = $urandom;
      vecs[v].last_pos  = 29;
      vecs[v].stall_pct = 0;
      vecs[v].lat       = $urandom_range(1, 8);
      vecs[v].hold      = $urandom_range(1, 4);
    end
    for (int k = 0; k < 8; k++) vecs[0].w[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    vecs[0].w[8]  = 32'hCAFEBABE;
    vecs[0].w[9]  = 32'hDEADBEEF;
    vecs[0].w[10] = 32'h01234567;
    vecs[0].lat = 50; vecs[0].hold = 1;
    vecs[1].w = vecs[0].w;
    vecs[1].stall_pct = 40; vecs[1].lat = 3; vecs[1].hold = 2;
    vecs[2].last_pos = 12;
    vecs[4].last_pos = -1;
    vecs[5].lat = 2; vecs[5].hold = 5;
    for (int v = 6; v < 10; v++) begin
      vecs[v].stall_pct = $urandom_range(0, 60);
      if ($urandom_range(0, 2) == 0) vecs[v].last_pos = $urandom_range(0, 28);
    end
    for (int v = 0; v < 10; v++) begin
      vecs[v].exp_err   = (vecs[v].last_pos != 29);
      vecs[v].exp_start = (vecs[v].last_pos == 29);
    end

    // reset state, including while rst is held
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   256'(s_ready),    256'(1));
    chk("rst_start",   256'(core_start), 256'(0));
    chk("rst_err",     256'(frame_err),  256'(0));
    chk("rst_cnt",     256'(frame_cnt),  256'(0));
    check_operands("rst");
    #2 rst = 1'b0;

    for (int v = 0; v < 10; v++) run_vec(v, vecs[v]);

    // stray done while loading is ignored
    core_manual = 1'b1;
    @(negedge clk);
    core_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_ready", 256'(s_ready),    256'(1));
      chk("idle_done_start", 256'(core_start), 256'(0));
    end
    core_done = 1'b0;
    chk("idle_done_cnt", 256'(frame_cnt), 256'(model_cnt));
    @(negedge clk);
    core_manual = 1'b0;

    // reset while START is held by a slow core
    vecs[3].lat = 1000;
    core_lat = 1000;
    send_frame(vecs[3]);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_start", 256'(core_start), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", 256'(core_start), 256'(0));
    chk("mid_rst_ready", 256'(s_ready),    256'(1));
    chk("mid_rst_cnt",   256'(frame_cnt),  256'(0));
    exp_q.delete();
    exp_frame = '0;
    model_cnt = '0;
    check_operands("mid_rst");
    @(negedge clk);
    #2 rst = 1'b0;

    // clean frame after reset counts from zero again
    vecs[0].lat = 4;
    run_vec(10, vecs[0]);
    chk("err_width", 256'(err_long), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
